// File: rtl/nand_tree_pipe_pkg.sv
// rtl/nand_tree_pipe_pkg.sv - mode encoding and tree sizing helpers for nand_tree_pipe
// Contents:
//   tree_mode_e    : TM_AND, TM_NAND, TM_OR, TM_NOR (bit1 = OR family, bit0 = invert)
//   clog_base      : number of tree levels, never below 1
//   width_at       : partial-bit count entering level s
//   offset_at      : start of level s inside the flat partial-bit bus
//   identity_bit   : padding value that leaves the reduction unchanged
package nand_tree_pkg;

    typedef enum logic [1:0] {
        TM_AND  = 2'd0,
        TM_NAND = 2'd1,
        TM_OR   = 2'd2,
        TM_NOR  = 2'd3
    } tree_mode_e;

    function automatic int clog_base(input int n, input int b);
        int w;
        int l;
        w = n;
        l = 0;
        while (w > 1) begin
            w = (w + b - 1) / b;
            l++;
        end
        return (l < 1) ? 1 : l;
    endfunction

    // ceil(n / b^s), computed by repeated ceiling division so no overflow for big s
    function automatic int width_at(input int n, input int b, input int s);
        int w;
        w = n;
        for (int k = 0; k < s; k++) begin
            w = (w + b - 1) / b;
        end
        return w;
    endfunction

    function automatic int offset_at(input int n, input int b, input int s);
        int o;
        o = 0;
        for (int k = 0; k < s; k++) begin
            o += width_at(n, b, k);
        end
        return o;
    endfunction

    // AND family pads with 1, OR family pads with 0
    function automatic logic identity_bit(input logic [1:0] mode);
        return ~mode[1];
    endfunction

endpackage

// File: rtl/nand_tree_pipe_if.sv
// rtl/nand_tree_pipe_if.sv - operand/result handshake bundle for nand_tree_pipe
// Signals:
//   in_data/in_mode/in_valid  : operand offer (master -> slave)
//   in_ready                  : operand accepted (slave -> master)
//   out_data/out_mode/out_valid : reduction result (slave -> master)
//   out_ready                 : result consumed (master -> slave)
interface nand_tree_pipe_if #(
    parameter int N_IN = 7
);
    logic [N_IN-1:0] in_data;
    logic [1:0]      in_mode;
    logic            in_valid;
    logic            in_ready;
    logic            out_data;
    logic [1:0]      out_mode;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_mode, out_valid
    );

    modport slave (
        input  in_data, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_mode, out_valid
    );
endinterface

// File: rtl/nand_tree_pipe_stage.sv
// rtl/nand_tree_pipe_stage.sv - one registered reduction level of nand_tree_pipe
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   up_valid/up_ready/up_mode/up_data : partial bits from the previous level
//   dn_valid/dn_ready/dn_mode/dn_data : registered partial bits to the next level
// LAST=1 folds the NAND/NOR inversion into this level's register.
module nand_tree_stage
    import nand_tree_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int FANIN = 4,
    parameter bit LAST  = 1'b0,
    localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [1:0]       up_mode,
    input  logic [IN_W-1:0]  up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [1:0]       dn_mode,
    output logic [OUT_W-1:0] dn_data
);
    localparam int PAD_W = OUT_W * FANIN;

    logic             valid_q, valid_d;
    logic [1:0]       mode_q, mode_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] red;
    logic             op_or;
    logic             load;

    always_comb begin
        op_or  = (up_mode == TM_OR) || (up_mode == TM_NOR);
        padded = {PAD_W{identity_bit(up_mode)}};
        padded[IN_W-1:0] = up_data;
        red = '0;
        for (int g = 0; g < OUT_W; g++) begin
            red[g] = op_or ? |padded[g*FANIN +: FANIN] : &padded[g*FANIN +: FANIN];
        end
        if (LAST) begin
            red = red ^ {OUT_W{up_mode[0]}};
        end
    end

    // An empty slot, or one whose contents leave this cycle, can take new data;
    // this lets bubbles collapse instead of propagating.
    always_comb begin
        up_ready = ~valid_q | dn_ready;
        load     = up_valid & up_ready;
        valid_d  = up_ready ? up_valid : valid_q;
        mode_d   = load ? up_mode : mode_q;
        data_d   = load ? red : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= 2'd0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_mode  = mode_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/nand_tree_pipe.sv
// rtl/nand_tree_pipe.sv - pipelined N-input AND/NAND/OR/NOR reduction tree
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   bus         : nand_tree_pipe_if.slave (in_* operand handshake, out_* result handshake)
//   stat_clr    : sync clear of the transfer counter (NAND_TREE_PIPE_STATS_EN only)
//   stat_count  : saturating count of result transfers (NAND_TREE_PIPE_STATS_EN only)
// One register level per tree level; in_ready is combinational from out_ready.
module nand_tree_pipe
    import nand_tree_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int FANIN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    nand_tree_pipe_if.slave     bus
`ifdef NAND_TREE_PIPE_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [15:0]         stat_count
`endif
);
    localparam int LEVELS  = clog_base(N_IN, FANIN);
    localparam int BUS_W   = offset_at(N_IN, FANIN, LEVELS + 1);
    localparam int OUT_OFF = offset_at(N_IN, FANIN, LEVELS);

    // All levels' partial bits packed end to end: level s sits at offset_at(s).
    logic [BUS_W-1:0] lvl_data;
    logic [LEVELS:0]  lvl_valid;
    logic [LEVELS:0]  lvl_ready;
    logic [1:0]       lvl_mode [LEVELS+1];

    assign lvl_data[N_IN-1:0] = bus.in_data;
    assign lvl_valid[0]       = bus.in_valid;
    assign lvl_mode[0]        = bus.in_mode;
    assign lvl_ready[LEVELS]  = bus.out_ready;

    for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
        localparam int IW = width_at(N_IN, FANIN, s);
        localparam int OW = width_at(N_IN, FANIN, s + 1);
        localparam int IO = offset_at(N_IN, FANIN, s);
        localparam int OO = offset_at(N_IN, FANIN, s + 1);

        nand_tree_stage #(
            .IN_W  (IW),
            .FANIN (FANIN),
            .LAST  (s == LEVELS - 1)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (lvl_valid[s]),
            .up_ready (lvl_ready[s]),
            .up_mode  (lvl_mode[s]),
            .up_data  (lvl_data[IO +: IW]),
            .dn_valid (lvl_valid[s+1]),
            .dn_ready (lvl_ready[s+1]),
            .dn_mode  (lvl_mode[s+1]),
            .dn_data  (lvl_data[OO +: OW])
        );
    end

    assign bus.in_ready  = lvl_ready[0];
    assign bus.out_valid = lvl_valid[LEVELS];
    assign bus.out_mode  = lvl_mode[LEVELS];
    assign bus.out_data  = lvl_data[OUT_OFF];

`ifdef NAND_TREE_PIPE_STATS_EN
    logic [15:0] stat_count_q, stat_count_d;

    // Clear takes priority over a same-cycle transfer.
    always_comb begin
        stat_count_d = stat_count_q;
        if (stat_clr) begin
            stat_count_d = 16'd0;
        end else if (lvl_valid[LEVELS] && bus.out_ready && (stat_count_q != 16'hFFFF)) begin
            stat_count_d = stat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count_q <= 16'd0;
        end else begin
            stat_count_q <= stat_count_d;
        end
    end

    assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_nand_tree_pipe.sv
// tb/tb_nand_tree_pipe.sv - scoreboard bench for nand_tree_pipe (7/4, 1/2 and 17/4 configurations)
module tb_nand_tree_pipe;
    import nand_tree_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       d;
        logic [1:0] m;
        int         cyc;
        int         lat;
    } exp_t;

    exp_t sb7[$];
    exp_t sb1[$];
    exp_t sb17[$];

    nand_tree_pipe_if #(.N_IN(7))  b7();
    nand_tree_pipe_if #(.N_IN(1))  b1();
    nand_tree_pipe_if #(.N_IN(17)) b17();

`ifdef NAND_TREE_PIPE_STATS_EN
    logic        stat_clr7 = 1'b0;
    logic        stat_clr_o = 1'b0;
    logic [15:0] sc7, sc1, sc17;
`endif

    nand_tree_pipe #(.N_IN(7), .FANIN(4)) dut7 (
        .clk(clk), .rst_n(rst_n), .bus(b7)
`ifdef NAND_TREE_PIPE_STATS_EN
        , .stat_clr(stat_clr7), .stat_count(sc7)
`endif
    );
    nand_tree_pipe #(.N_IN(1), .FANIN(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef NAND_TREE_PIPE_STATS_EN
        , .stat_clr(stat_clr_o), .stat_count(sc1)
`endif
    );
    nand_tree_pipe #(.N_IN(17), .FANIN(4)) dut17 (
        .clk(clk), .rst_n(rst_n), .bus(b17)
`ifdef NAND_TREE_PIPE_STATS_EN
        , .stat_clr(stat_clr_o), .stat_count(sc17)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string name, input exp_t e, input logic d, input logic [1:0] m);
        chk({name, "_data"}, {31'd0, d}, {31'd0, e.d});
        chk({name, "_mode"}, {30'd0, m}, {30'd0, e.m});
        if (e.lat >= 0) chk({name, "_lat"}, cyc - e.cyc, e.lat);
    endtask

    task automatic unexpected(input string name, input logic d);
        total++;
        bad++;
        $display("FAIL %s: got unexpected result %0b expected none", name, d);
    endtask

    // Monitor: every presented-and-consumed result is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b7.out_valid && b7.out_ready) begin
                if (sb7.size() == 0) unexpected("out7", b7.out_data);
                else cmp_out("out7", sb7.pop_front(), b7.out_data, b7.out_mode);
            end
            if (b1.out_valid && b1.out_ready) begin
                if (sb1.size() == 0) unexpected("out1", b1.out_data);
                else cmp_out("out1", sb1.pop_front(), b1.out_data, b1.out_mode);
            end
            if (b17.out_valid && b17.out_ready) begin
                if (sb17.size() == 0) unexpected("out17", b17.out_data);
                else cmp_out("out17", sb17.pop_front(), b17.out_data, b17.out_mode);
            end
        end
    end

    task automatic offer7(input logic [6:0] d, input logic [1:0] m);
        b7.in_data  = d;
        b7.in_mode  = m;
        b7.in_valid = 1'b1;
    endtask

    task automatic wait_acc7(input logic ed, input logic [1:0] m, input int lat);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (b7.in_ready) begin
                sb7.push_back('{ed, m, cyc, lat});
                ok = 1'b1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept7_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        b7.in_valid = 1'b0;
    endtask

    task automatic send7(input logic [6:0] d, input logic [1:0] m, input logic ed, input int lat);
        offer7(d, m);
        wait_acc7(ed, m, lat);
    endtask

    task automatic send1(input logic d, input logic [1:0] m, input logic ed, input int lat);
        b1.in_data  = d;
        b1.in_mode  = m;
        b1.in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready1", {31'd0, b1.in_ready}, 32'd1);
        sb1.push_back('{ed, m, cyc, lat});
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
    endtask

    task automatic send17(input logic [16:0] d, input logic [1:0] m, input logic ed, input int lat);
        b17.in_data  = d;
        b17.in_mode  = m;
        b17.in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready17", {31'd0, b17.in_ready}, 32'd1);
        sb17.push_back('{ed, m, cyc, lat});
        @(posedge clk);
        #1;
        b17.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        b7.in_data = '0;  b7.in_mode = 2'd0;  b7.in_valid = 1'b0;  b7.out_ready = 1'b1;
        b1.in_data = '0;  b1.in_mode = 2'd0;  b1.in_valid = 1'b0;  b1.out_ready = 1'b1;
        b17.in_data = '0; b17.in_mode = 2'd0; b17.in_valid = 1'b0; b17.out_ready = 1'b1;

        idle(2);
        chk("rst_out_valid", {31'd0, b7.out_valid}, 32'd0);
        chk("rst_out_data",  {31'd0, b7.out_data},  32'd0);
        chk("rst_out_mode",  {30'd0, b7.out_mode},  32'd0);
        chk("rst_in_ready",  {31'd0, b7.in_ready},  32'd1);
        rst_n = 1'b1;
        idle(2);

        // single NAND of all ones, two-cycle latency
        send7(7'h7F, TM_NAND, 1'b0, 2);
        idle(4);

        // back-to-back, one result per cycle
        send7(7'h7E, TM_NAND, 1'b1, 2);
        send7(7'h00, TM_NOR,  1'b1, 2);
        send7(7'h40, TM_OR,   1'b1, 2);
        idle(4);

        // backpressure: two fit, third waits, head result held
        b7.out_ready = 1'b0;
        send7(7'h7F, TM_AND, 1'b1, -1);
        send7(7'h00, TM_OR,  1'b0, -1);
        offer7(7'h3F, TM_NAND);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  {31'd0, b7.in_ready},  32'd0);
            chk("stall_out_valid", {31'd0, b7.out_valid}, 32'd1);
            chk("stall_out_data",  {31'd0, b7.out_data},  32'd1);
            chk("stall_out_mode",  {30'd0, b7.out_mode},  32'd0);
        end
        @(posedge clk);
        #1;
        b7.out_ready = 1'b1;
        wait_acc7(1'b1, TM_NAND, -1);
        idle(5);
        chk("stall_drained", sb7.size(), 32'd0);

        // asynchronous reset with two results in flight
        send7(7'h00, TM_NOR, 1'b1, -1);
        send7(7'h7F, TM_AND, 1'b1, -1);
        chk("pre_rst_out_valid", {31'd0, b7.out_valid}, 32'd1);
        chk("pre_rst_out_mode",  {30'd0, b7.out_mode},  32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, b7.out_valid}, 32'd0);
        chk("async_rst_out_data",  {31'd0, b7.out_data},  32'd0);
        chk("async_rst_out_mode",  {30'd0, b7.out_mode},  32'd0);
        chk("async_rst_in_ready",  {31'd0, b7.in_ready},  32'd1);
        sb7.delete();
        idle(1);
        rst_n = 1'b1;
        idle(6);

        // single-input tree: one stage, inversion only
        send1(1'b1, TM_NOR,  1'b0, 1);
        send1(1'b0, TM_NAND, 1'b1, 1);
        send1(1'b1, TM_AND,  1'b1, 1);

        // 17 inputs, fan-in 4: three levels
        send17(17'h1FFFF, TM_AND, 1'b1, 3);
        send17(17'h1FFFE, TM_AND, 1'b0, 3);
        send17(17'h00000, TM_NOR, 1'b1, 3);
        send17(17'h00100, TM_NOR, 1'b0, 3);
        idle(6);

`ifdef NAND_TREE_PIPE_STATS_EN
        stat_clr7 = 1'b1;
        idle(1);
        stat_clr7 = 1'b0;
        chk("stat_clr_idle", {16'd0, sc7}, 32'd0);
        begin
            int n;
            n = 0;
            offer7(7'h7F, TM_AND);
            for (int i = 0; i < 70000 && n < 65540; i++) begin
                @(negedge clk);
                if (b7.in_ready) begin
                    sb7.push_back('{1'b1, TM_AND, cyc, -1});
                    n++;
                end
                @(posedge clk);
                #1;
            end
            b7.in_valid = 1'b0;
            chk("stat_issued", n, 32'd65540);
        end
        idle(5);
        chk("stat_saturate", {16'd0, sc7}, 32'h0000FFFF);
        send7(7'h7F, TM_AND, 1'b1, -1);
        idle(1);
        chk("stat_clr_xfer_valid", {31'd0, b7.out_valid}, 32'd1);
        stat_clr7 = 1'b1;
        idle(1);
        stat_clr7 = 1'b0;
        chk("stat_clr_wins", {16'd0, sc7}, 32'd0);
        idle(3);
`endif

        chk("sb7_empty",  sb7.size(),  32'd0);
        chk("sb1_empty",  sb1.size(),  32'd0);
        chk("sb17_empty", sb17.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
